// File: rtl/pipe_pkg.sv
// pipe_pkg: types and default sizing shared by the memory-port arbiter slice.
//   ADDR_W_DEF / DATA_W_DEF / TIMEOUT_DEF : default parameter values
//   arb_state_t : arbiter FSM states
//   arb_owner_t : which pipeline channel owns the current bus transfer
package pipe_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2,
        DONE     = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_MEM = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: shared single-port memory bus.
//   master modport (arbiter): drives bus_req/bus_we/bus_addr/bus_wdata/bus_be,
//                             receives bus_ready/bus_rdata
//   slave modport (memory)  : the mirror image
interface mem_port_arbiter_if
    import pipe_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W-1:0]     bus_wdata;
    logic [DATA_W/8-1:0]   bus_be;
    logic                  bus_ready;
    logic [DATA_W-1:0]     bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ready, bus_rdata
    );

endinterface

// File: rtl/arb_timeout_ctr.sv
// arb_timeout_ctr: counts consecutive cycles with en=1 and flags the
// TIMEOUT-th such cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : arbiter is in a BUSY state (count clears whenever low)
//   expired    : high during the TIMEOUT-th consecutive enabled cycle
module arb_timeout_ctr
    import pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired = en && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between the fetch (IF) and the
// MEM-stage ports of a pipeline. MEM wins simultaneous requests; a transfer
// always runs to completion and is reported by a one-cycle valid pulse.
//   clk, rst_n           : clock, asynchronous active-low reset
//   if_req/if_addr       : fetch request;  if_rdata/if_valid  : fetch result
//   mem_req/mem_we/...   : data request;   mem_rdata/mem_valid: data result
//   stall_if, stall_mem  : combinational stalls while a request is pending
//   bus (master modport) : shared memory bus
//   timeout_err          : sticky bus timeout flag
// Optional feature: define MEM_ARB_TIMEOUT_EN to abandon a transfer after
// TIMEOUT BUSY cycles without bus_ready (otherwise waits forever and
// timeout_err is tied low).
module mem_port_arbiter
    import pipe_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_valid,
    output logic                stall_if,
    output logic                stall_mem,
    mem_port_arbiter_if.master  bus,
    output logic                timeout_err
);

    arb_state_t          state_q, state_d;
    arb_owner_t          owner_q;
    logic                dropped_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] be_q;
    logic [DATA_W-1:0]   if_rdata_q, mem_rdata_q;

    logic                busy;
    logic                owner_req;
    logic                timed_out;
    logic                xfer_done;
    logic [DATA_W-1:0]   xfer_data;

    assign busy      = (state_q == IF_BUSY) || (state_q == MEM_BUSY);
    assign owner_req = (owner_q == OWNER_MEM) ? mem_req : if_req;
    assign xfer_done = busy && (bus.bus_ready || timed_out);
    // bus_ready takes precedence over a timeout landing in the same cycle.
    assign xfer_data = bus.bus_ready ? bus.bus_rdata : '0;

`ifdef MEM_ARB_TIMEOUT_EN
    logic expired;
    logic timeout_err_q;

    arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (busy),
        .expired (expired)
    );

    assign timed_out = expired && !bus.bus_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err_q <= 1'b0;
        end else if (timed_out) begin
            timeout_err_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT != 0);
    assign timed_out          = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    state_d = MEM_BUSY;
                end else if (if_req) begin
                    state_d = IF_BUSY;
                end
            end
            IF_BUSY, MEM_BUSY: begin
                if (xfer_done) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWNER_IF;
            dropped_q   <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (mem_req) begin
                    owner_q   <= OWNER_MEM;
                    dropped_q <= 1'b0;
                    addr_q    <= mem_addr;
                    we_q      <= mem_we;
                    wdata_q   <= mem_wdata;
                    be_q      <= mem_be;
                end else if (if_req) begin
                    owner_q   <= OWNER_IF;
                    dropped_q <= 1'b0;
                    addr_q    <= if_addr;
                    we_q      <= 1'b0;
                    wdata_q   <= '0;
                    be_q      <= '1;
                end
            end
            if (busy) begin
                // Once the owner lets go (e.g. a flush) the transfer still
                // finishes on the bus but is never reported to that channel.
                if (!owner_req) begin
                    dropped_q <= 1'b1;
                end
                if (xfer_done && owner_req && !dropped_q) begin
                    if (owner_q == OWNER_MEM) begin
                        mem_rdata_q <= xfer_data;
                    end else begin
                        if_rdata_q <= xfer_data;
                    end
                end
            end
        end
    end

    assign if_valid  = (state_q == DONE) && (owner_q == OWNER_IF)  && !dropped_q;
    assign mem_valid = (state_q == DONE) && (owner_q == OWNER_MEM) && !dropped_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;

    assign stall_if  = if_req  && !if_valid;
    assign stall_mem = mem_req && !mem_valid;

    assign bus.bus_req   = busy;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_be    = be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table of single transfers applied in a loop, plus
// hand-written sequences for priority, flush, reset and timeout cases.
// Completions are checked against a scoreboard queue.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_be = '0;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        stall_if;
    logic        stall_mem;
    logic        timeout_err;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_valid    (if_valid),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_rdata   (mem_rdata),
        .mem_valid   (mem_valid),
        .stall_if    (stall_if),
        .stall_mem   (stall_mem),
        .bus         (bus_if.master),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          delay;
        logic [31:0] rdata;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        bit          is_mem;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[6];
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    // Completion monitor: every valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && (if_valid || mem_valid)) begin
            if (if_valid && mem_valid) begin
                chk("sb_both_valid", 32'd1, 32'd0);
            end else if (sb_q.size() == 0) begin
                chk("sb_unexpected_valid", {31'd0, mem_valid}, {31'd0, if_valid});
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_channel", {31'd0, mem_valid}, {31'd0, e.is_mem});
                chk("sb_rdata", mem_valid ? mem_rdata : if_rdata, e.data);
            end
        end
    end

    task automatic drive_req(input vec_t v);
        if (v.is_mem) begin
            mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr;
            mem_wdata = v.wdata; mem_be = v.be;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [3:0] exp_be;
        exp_be = v.is_mem ? v.be : 4'hF;
        @(negedge clk);                                   // T0: sampled in IDLE
        drive_req(v);
        sb_q.push_back('{is_mem: v.is_mem, data: v.exp_rdata});
        #1;
        chk("t0_stall", {31'd0, v.is_mem ? stall_mem : stall_if}, 32'd1);
        @(negedge clk);                                   // T1: BUSY
        chk("t1_bus_req", {31'd0, bus_if.bus_req}, 32'd1);
        chk("t1_bus_addr", bus_if.bus_addr, v.addr);
        chk("t1_bus_we", {31'd0, bus_if.bus_we}, {31'd0, v.is_mem && v.we});
        chk("t1_bus_be", {28'd0, bus_if.bus_be}, {28'd0, exp_be});
        if (v.is_mem) chk("t1_bus_wdata", bus_if.bus_wdata, v.wdata);
        for (int d = 0; d < v.delay; d++) begin
            bus_if.bus_ready = 1'b0;
            bus_if.bus_rdata = $urandom;
            @(negedge clk);
            chk("wait_bus_addr", bus_if.bus_addr, v.addr);
            chk("wait_bus_req", {31'd0, bus_if.bus_req}, 32'd1);
        end
        bus_if.bus_ready = 1'b1;
        bus_if.bus_rdata = v.rdata;
        @(negedge clk);                                   // T2: DONE
        bus_if.bus_ready = 1'b0;
        bus_if.bus_rdata = $urandom;
        chk("t2_valid", {31'd0, v.is_mem ? mem_valid : if_valid}, 32'd1);
        chk("t2_other_valid", {31'd0, v.is_mem ? if_valid : mem_valid}, 32'd0);
        chk("t2_stall", {31'd0, v.is_mem ? stall_mem : stall_if}, 32'd0);
        if_req = 1'b0; mem_req = 1'b0;
        @(negedge clk);                                   // T3: back in IDLE
        chk("t3_valid_low", {30'd0, if_valid, mem_valid}, 32'd0);
        chk("t3_bus_req_low", {31'd0, bus_if.bus_req}, 32'd0);
    endtask

    initial begin
        vec_t v;
        int   busy_cycles;

        vecs[0] = '{0, 0, 32'h0000_0100, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[1] = '{1, 0, 32'h0000_0204, 32'h0, 4'hF, 5, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[2] = '{1, 1, 32'h0000_0208, 32'hA5A5_A5A5, 4'h3, 1, 32'h0000_0000, 32'h0000_0000};
        vecs[3] = '{0, 0, 32'h0000_0104, 32'h0, 4'hF, 2, 32'h0123_4567, 32'h0123_4567};
        vecs[4] = '{1, 0, 32'hFFFF_FFFC, 32'h0, 4'hF, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[5] = '{1, 1, 32'h0000_0000, 32'h89AB_CDEF, 4'hF, 0, 32'h0000_0042, 32'h0000_0042};

        bus_if.bus_ready = 1'b0;
        bus_if.bus_rdata = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
        chk("rst_bus_addr", bus_if.bus_addr, 32'd0);
        chk("rst_valids", {30'd0, if_valid, mem_valid}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        rst_n = 1'b1;

        // Bus_ready while IDLE must be ignored
        @(negedge clk);
        bus_if.bus_ready = 1'b1;
        bus_if.bus_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        bus_if.bus_ready = 1'b0;
        chk("idle_ready_ignored", {30'd0, if_valid, mem_valid}, 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Each channel's result holds until its own next completion
        chk("hold_if_rdata", if_rdata, 32'h0123_4567);
        chk("hold_mem_rdata", mem_rdata, 32'h0000_0042);

        // Simultaneous requests: store first, then fetch
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0000_0300;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0200;
        mem_wdata = 32'h1234_5678; mem_be = 4'hF;
        sb_q.push_back('{is_mem: 1'b1, data: 32'h0});
        sb_q.push_back('{is_mem: 1'b0, data: 32'h55AA_55AA});
        @(negedge clk);
        chk("prio_addr", bus_if.bus_addr, 32'h0000_0200);
        chk("prio_we", {31'd0, bus_if.bus_we}, 32'd1);
        chk("prio_wdata", bus_if.bus_wdata, 32'h1234_5678);
        chk("prio_be", {28'd0, bus_if.bus_be}, 32'hF);
        bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'h0;
        @(negedge clk);
        bus_if.bus_ready = 1'b0;
        chk("prio_mem_valid", {31'd0, mem_valid}, 32'd1);
        chk("prio_stall_if_store", {31'd0, stall_if}, 32'd1);
        mem_req = 1'b0;
        @(negedge clk);
        chk("prio_stall_if_idle", {31'd0, stall_if}, 32'd1);
        @(negedge clk);
        chk("prio_fetch_addr", bus_if.bus_addr, 32'h0000_0300);
        chk("prio_fetch_we", {31'd0, bus_if.bus_we}, 32'd0);
        chk("prio_fetch_be", {28'd0, bus_if.bus_be}, 32'hF);
        chk("prio_stall_if_busy", {31'd0, stall_if}, 32'd1);
        bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'h55AA_55AA;
        @(negedge clk);
        bus_if.bus_ready = 1'b0;
        chk("prio_if_valid", {31'd0, if_valid}, 32'd1);
        chk("prio_stall_if_done", {31'd0, stall_if}, 32'd0);
        if_req = 1'b0;
        @(negedge clk);

        // Fetch flushed mid-transfer: completes silently
        if_req = 1'b1; if_addr = 32'h0000_0400;
        @(negedge clk);
        chk("flush_bus_req", {31'd0, bus_if.bus_req}, 32'd1);
        if_req = 1'b0;
        @(negedge clk);
        chk("flush_not_aborted", {31'd0, bus_if.bus_req}, 32'd1);
        chk("flush_addr_stable", bus_if.bus_addr, 32'h0000_0400);
        bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'h1111_1111;
        @(negedge clk);
        bus_if.bus_ready = 1'b0;
        chk("flush_no_valid", {30'd0, if_valid, mem_valid}, 32'd0);
        chk("flush_if_rdata_held", if_rdata, 32'h55AA_55AA);
        @(negedge clk);
        chk("flush_released", {31'd0, bus_if.bus_req}, 32'd0);
        v = '{1, 0, 32'h0000_0500, 32'h0, 4'hF, 1, 32'h7777_0000, 32'h7777_0000};
        run_vec(v);

`ifdef MEM_ARB_TIMEOUT_EN
        // Bus never answers: give up after TIMEOUT busy cycles
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0600;
        sb_q.push_back('{is_mem: 1'b1, data: 32'h0});
        bus_if.bus_rdata = 32'hBAD0_BAD0;
        busy_cycles = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!bus_if.bus_req) break;
            busy_cycles++;
        end
        chk("to_busy_cycles", busy_cycles, 32'd8);
        chk("to_mem_valid", {31'd0, mem_valid}, 32'd1);
        chk("to_mem_rdata", mem_rdata, 32'd0);
        chk("to_err_set", {31'd0, timeout_err}, 32'd1);
        mem_req = 1'b0;
        v = '{0, 0, 32'h0000_0108, 32'h0, 4'hF, 0, 32'h2222_3333, 32'h2222_3333};
        run_vec(v);
        chk("to_err_sticky", {31'd0, timeout_err}, 32'd1);
`else
        busy_cycles = 0;
        chk("no_timeout_err", {31'd0, timeout_err}, {31'd0, busy_cycles[0]});
`endif

        // Reset while MEM_BUSY
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0700;
        @(negedge clk);
        chk("rstmid_busy", {31'd0, bus_if.bus_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
        chk("rstmid_bus_addr", bus_if.bus_addr, 32'd0);
        chk("rstmid_valids", {30'd0, if_valid, mem_valid}, 32'd0);
        chk("rstmid_mem_rdata", mem_rdata, 32'd0);
        chk("rstmid_if_rdata", if_rdata, 32'd0);
        chk("rstmid_timeout_err", {31'd0, timeout_err}, 32'd0);
        mem_req = 1'b0;
        bus_if.bus_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_if.bus_ready = 1'b0;
        chk("rstmid_no_valid", {30'd0, if_valid, mem_valid}, 32'd0);
        chk("rstmid_idle", {31'd0, bus_if.bus_req}, 32'd0);

        @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byte enables are DATA_W/8 wide.
REQ-003 SHALL have parameter TIMEOUT, default 255, max bus wait cycles (used only with REQ-030 macro).
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports as follows:
  clk  input  1  rising-edge clock
  rst_n  input  1  asynchronous active-low reset
  if_req  input  1  fetch-stage read request
  if_addr  input  ADDR_W  fetch address
  if_rdata  output  DATA_W  fetched word
  if_valid  output  1  one-cycle fetch completion
  mem_req  input  1  MEM-stage access request
  mem_we  input  1  1=store, 0=load
  mem_addr  input  ADDR_W  data address
  mem_wdata  input  DATA_W  store data
  mem_be  input  DATA_W/8  store byte enables
  mem_rdata  output  DATA_W  load data
  mem_valid  output  1  one-cycle data completion
  stall_if  output  1  hold IF/ID
  stall_mem  output  1  hold whole pipeline up to MEM
  bus_req  output  1  shared memory request
  bus_we  output  1  shared memory write
  bus_addr  output  ADDR_W  shared memory address
  bus_wdata  output  DATA_W  shared memory write data
  bus_be  output  DATA_W/8  shared memory byte enables
  bus_ready  input  1  transfer completes this cycle
  bus_rdata  input  DATA_W  read data, valid when bus_ready=1
  timeout_err  output  1  sticky bus timeout flag

Function
REQ-010 SHALL implement FSM states IDLE, IF_BUSY, MEM_BUSY, DONE.
REQ-011 SHALL sample requests only in IDLE: mem_req=1 -> MEM_BUSY; else if_req=1 -> IF_BUSY; else stay IDLE.
REQ-012 SHALL give mem_req strict priority on simultaneous requests (older instruction first).
REQ-013 SHALL latch the winner's address/we/wdata/be on the IDLE->BUSY edge; bus_* outputs driven from these registers only.
REQ-014 SHALL hold bus_req=1 with stable bus_* throughout BUSY; IF_BUSY drives bus_we=0, bus_be all-ones.
REQ-015 SHALL end BUSY on the first cycle with bus_ready=1, register bus_rdata, go to DONE.
REQ-016 SHALL pulse exactly one of if_valid/mem_valid for the single DONE cycle, then return to IDLE.
REQ-017 SHALL hold if_rdata/mem_rdata stable from DONE until that channel's next completion.
REQ-018 SHALL give minimum latency of 2 cycles request-to-valid (sample T0, bus_ready at T1, valid at T2), next sample at T3.
REQ-019 SHALL drive stall_if = if_req & ~if_valid, and stall_mem = mem_req & ~mem_valid (combinational).
REQ-020 SHALL never abort a bus transfer; if the owner drops its request mid-transfer (e.g. flush), the transfer completes and the valid pulse is suppressed.
REQ-021 SHALL ignore bus_ready outside BUSY.

Reset
REQ-025 SHALL, on rst_n=0, asynchronously force IDLE, bus_req=0, if_valid=mem_valid=0, if_rdata=mem_rdata=0, latched bus_* = 0, timeout_err=0.
REQ-026 SHALL, on reset mid-transfer, drop bus_req immediately with no completion pulse.

Configuration
REQ-030 SHALL, with MEM_ARB_TIMEOUT_EN defined, count BUSY cycles; at TIMEOUT cycles without bus_ready, drop bus_req, go DONE with rdata=0, and set timeout_err sticky until reset.
REQ-031 SHALL, without MEM_ARB_TIMEOUT_EN, wait indefinitely in BUSY and tie timeout_err to 0; the port remains.

Structure
REQ-035 SHALL place the FSM state enum and default ADDR_W/DATA_W/TIMEOUT constants in shared package pipe_pkg.
REQ-036 SHALL implement the wait counter as sub-module arb_timeout_ctr, instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-040 SHALL cover: if_req=1, addr 0x100, bus_ready at T1 with rdata 0xDEADBEEF -> if_valid pulse T2, if_rdata=0xDEADBEEF, stall_if high T0-T1.
REQ-041 SHALL cover: if_req and mem_req (store 0x200, wdata 0x12345678, be 0xF) together -> store first, then fetch; stall_if stays high until fetch completes.
REQ-042 SHALL cover: load with bus_ready delayed 5 cycles -> bus_addr stable 5 cycles, mem_valid exactly 1 cycle after ready.
REQ-043 SHALL cover: if_req dropped while IF_BUSY -> transfer completes, no if_valid, next sampled request served normally.
REQ-044 SHALL cover: rst_n low while MEM_BUSY -> bus_req low same cycle, all outputs at reset values, no mem_valid.
REQ-045 SHALL cover: with MEM_ARB_TIMEOUT_EN, TIMEOUT=8, bus_ready never high -> bus_req drops after 8 cycles, mem_valid with rdata 0, timeout_err=1 until reset.
